mat_rowsum_seq: RTL and testbench

MAT_ROWSUM_SEQ -- requirements
Module: mat_rowsum_seq

---
 rtl/mat_rowsum_seq.sv | 127 ++++++++++++
 tb/tb_mat_rowsum_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_rowsum_seq.sv
// Sequential per-row reduction of a ROWS x COLS signed matrix, one column per cycle.
// Optional macro MAT_ROWSUM_SAT_EN saturates each row result to WIDTH bits instead of wrapping.
module mat_rowsum_seq #(
    parameter int unsigned ROWS  = 1,
    parameter int unsigned COLS  = 1,
    parameter int unsigned WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]  a,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [ROWS:1][WIDTH-1:0]          f
);

    localparam int unsigned ACC_W = WIDTH + $clog2(COLS) + 1;
    localparam int unsigned CW    = $clog2(COLS + 1);

`ifdef MAT_ROWSUM_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e                            state_q, state_d;
    logic [ROWS:1][COLS:1][WIDTH-1:0]  a_q, a_d;
    logic [ROWS:1][ACC_W-1:0]          acc_q, acc_d;
    logic [CW-1:0]                     col_q, col_d;
    logic [ROWS:1][WIDTH-1:0]          f_q, f_d;
    logic                              done_q, done_d;
    logic                              busy_q, busy_d;
    logic [ROWS:1][WIDTH-1:0]          sel;

    // Next-state, accumulate and result-format logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        col_d   = col_q;
        f_d     = f_q;
        done_d  = 1'b0;

        for (int unsigned r = 1; r <= ROWS; r++) begin
            sel[r] = '0;
            for (int unsigned c = 1; c <= COLS; c++) begin
                if (col_q == CW'(c)) begin
                    sel[r] = a_q[r][c];
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    acc_d   = '0;
                    col_d   = CW'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                for (int unsigned r = 1; r <= ROWS; r++) begin
                    acc_d[r] = acc_q[r] + {{(ACC_W-WIDTH){sel[r][WIDTH-1]}}, sel[r]};
                end
                // Last column: the result is formatted from the final sum so it is visible in FINISH
                if (col_q == CW'(COLS)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    for (int unsigned r = 1; r <= ROWS; r++) begin
`ifdef MAT_ROWSUM_SAT_EN
                        if ($signed(acc_d[r]) > $signed(SAT_MAX)) begin
                            f_d[r] = SAT_MAX[WIDTH-1:0];
                        end else if ($signed(acc_d[r]) < $signed(SAT_MIN)) begin
                            f_d[r] = SAT_MIN[WIDTH-1:0];
                        end else begin
                            f_d[r] = acc_d[r][WIDTH-1:0];
                        end
`else
                        f_d[r] = acc_d[r][WIDTH-1:0];
`endif
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            col_q   <= '0;
            f_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            col_q   <= col_d;
            f_q     <= f_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign f    = f_q;

endmodule

// File: tb/tb_mat_rowsum_seq.sv
// Scoreboard bench for mat_rowsum_seq: a 2x3 instance and a 1x1 instance, WIDTH=16.
module tb_mat_rowsum_seq;

    localparam int W = 16;

    typedef logic [2:1][3:1][W-1:0] mat_t;
    typedef struct {
        logic [31:0] f;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mat_t                  a1;
    logic                  start1, busy1, done1;
    logic [2:1][W-1:0]     f1;
    logic [1:1][1:1][W-1:0] a2;
    logic                  start2, busy2, done2;
    logic [1:1][W-1:0]     f2;

    mat_rowsum_seq #(.ROWS(2), .COLS(3), .WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .a(a1), .start(start1),
        .busy(busy1), .done(done1), .f(f1)
    );

    mat_rowsum_seq #(.ROWS(1), .COLS(1), .WIDTH(W)) u_dut1x1 (
        .clk(clk), .reset(reset), .a(a2), .start(start2),
        .busy(busy2), .done(done2), .f(f2)
    );

    exp_t q1[$];
    exp_t q2[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic mat_t mk(input int x11, input int x12, input int x13,
                                input int x21, input int x22, input int x23);
        mat_t m;
        m[1][1] = W'(x11); m[1][2] = W'(x12); m[1][3] = W'(x13);
        m[2][1] = W'(x21); m[2][2] = W'(x22); m[2][3] = W'(x23);
        return m;
    endfunction

    function automatic logic [31:0] ex(input int r1, input int r2);
        return {16'(r2), 16'(r1)};
    endfunction

    task automatic issue1(input mat_t m, input logic [31:0] e, input string nm);
        @(posedge clk); #1;
        a1     = m;
        start1 = 1'b1;
        q1.push_back('{e, cyc + 4, nm});
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic issue2(input int v, input string nm);
        @(posedge clk); #1;
        a2[1][1] = W'(v);
        start2   = 1'b1;
        q2.push_back('{{16'h0, 16'(v)}, cyc + 2, nm});
        @(posedge clk); #1;
        start2 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: %0d results outstanding, expected 0", q1.size() + q2.size());
            q1.delete();
            q2.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dut2x3_unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = q1.pop_front();
                    chk({e.name, "_f"}, f1, e.f);
                    chk({e.name, "_cycle"}, cyc, e.cyc);
                end
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dut1x1_unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = q2.pop_front();
                    chk({e.name, "_f"}, {16'h0, f2}, e.f);
                    chk({e.name, "_cycle"}, cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        a1     = '0;
        a2     = '0;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_done", 32'(done1), 32'd0);
        chk("reset_f", f1, 32'd0);
        chk("reset_busy_1x1", 32'(busy2), 32'd0);
        chk("reset_f_1x1", {16'h0, f2}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic sum with busy window: high for the 4 cycles after acceptance
        issue1(mk(1, 2, 3, -4, 5, -6), ex(6, -5), "basic");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("basic_busy_high", 32'(busy1), 32'd1);
        end
        @(negedge clk);
        chk("basic_busy_low", 32'(busy1), 32'd0);
        wait_idle(20);

`ifdef MAT_ROWSUM_SAT_EN
        issue1(mk(20000, 20000, 20000, -20000, -20000, -20000), ex(32767, -32768), "overflow");
        wait_idle(20);
        issue1(mk(32767, 32767, 32767, -32768, -32768, -32768), ex(32767, -32768), "extremes");
`else
        issue1(mk(20000, 20000, 20000, -20000, -20000, -20000), ex(-5536, 5536), "overflow");
        wait_idle(20);
        issue1(mk(32767, 32767, 32767, -32768, -32768, -32768), ex(32765, -32768), "extremes");
`endif
        wait_idle(20);

        // Start held for 6 cycles with a changing after acceptance
        @(posedge clk); #1;
        a1     = mk(100, -200, 300, 7, 8, 9);
        start1 = 1'b1;
        q1.push_back('{ex(200, 24), cyc + 4, "freeze_first"});
        @(posedge clk); #1;
        a1 = mk(1000, 1000, 1000, -1, -1, -1);
        repeat (4) @(posedge clk);
        #1;
        q1.push_back('{ex(3000, -3), cyc + 4, "freeze_second"});
        @(posedge clk); #1;
        start1 = 1'b0;
        a1     = mk(5, 5, 5, 5, 5, 5);
        wait_idle(20);

        // Reset two cycles after start aborts the operation
        @(posedge clk); #1;
        a1     = mk(9, 9, 9, 9, 9, 9);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_done", 32'(done1), 32'd0);
        chk("abort_f", f1, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        issue1(mk(-1, -2, -3, 10, 20, 30), ex(-6, 60), "after_reset");
        wait_idle(20);

        // 1x1 instance: two-cycle latency
        issue2(-7, "single_neg7");
        wait_idle(10);
        issue2(32767, "single_max");
        wait_idle(10);
        issue2(-32768, "single_min");
        wait_idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
